data_memory_arbiter: RTL and testbench
======================================

Name: data_memory_arbiter

Overview:
- Shares the single-port DATA_MEMORY between two requesters.
  - Port 0: CPU load/store stage.
  - Port 1: program/data loader or debug port.
- Each port has a req/ack handshake. Grants are round-robin, and one memory access is in flight at a time.
- Sits between the requesters and DATA_MEMORY, driving its address bus, write-data bus and MW1 write strobe.
- Registers the memory read data so returned data is stable for the acked port.

Parameters:
- ADDR_W, 32, address width; matches the memory address bus.
- WDATA_W, 32, write-data width; matches the memory write-data bus.
- RDATA_W, 16, read-data width; matches the memory data_out.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0, req1  in  1  access request per port; held with its payload until the matching ack.
- addr0, addr1  in  ADDR_W  request address per port.
- wdata0, wdata1  in  WDATA_W  write data per port.
- we0, we1  in  1  per port: 1 = write, 0 = read.
- ack0, ack1  out  1  one-cycle completion pulse per port.
- rdata0, rdata1  out  RDATA_W  read data per port; valid while the matching ack is high.
- mem_addr  out  ADDR_W  to the memory address bus.
- mem_wdata  out  WDATA_W  to the memory write-data bus.
- mem_we  out  1  to memory MW1.
- mem_rdata  in  RDATA_W  from memory data_out; combinational read.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - State = IDLE.
  - ack0, ack1, mem_we, busy = 0.
  - mem_addr, mem_wdata, rdata0, rdata1 = 0.
  - last_grant = 1, so port 0 wins the first tie.
- State machine: IDLE -> ACCESS -> ACK -> IDLE. No other transitions.
- IDLE:
  - Samples req0 and req1.
  - If neither is high, stay in IDLE.
  - If exactly one is high, grant that port.
  - If both are high, grant the port that is not last_grant.
  - On a grant, latch the port's addr, wdata and we into internal registers, set gnt_id, and go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_addr and mem_wdata are driven from the latched registers.
  - mem_we = latched we.
  - At the end of the cycle, mem_rdata is captured into the rdata register of gnt_id; this happens for reads only.
  - Update last_grant = gnt_id.
  - Go to ACK.
- ACK (exactly 1 cycle):
  - ack[gnt_id] = 1.
  - mem_we = 0; mem_addr holds its value.
  - Go to IDLE.
- Latency:
  - Request sampled in IDLE at cycle N.
  - Memory access in cycle N+1.
  - ack in cycle N+2.
  - Earliest next grant is sampled in cycle N+3.
  - Throughput: one access per 3 cycles.
- Requester rules:
  - Must keep addr, wdata and we stable from req rise until ack.
  - Must drop req in the cycle after ack, unless it is issuing a new request. A req still high in IDLE counts as a new request.
- rdataX holds its last read value until overwritten by the next read for that port. It is not cleared after ack.
- Writes leave rdataX unchanged.
- req changes during ACCESS or ACK are ignored.
- A request deasserted before grant is dropped and produces no ack.
- Fairness: with both ports requesting continuously, grants alternate strictly 0,1,0,1,…
- mem_we is asserted only in ACCESS, never for more than 1 consecutive cycle.
- Reset mid-operation:
  - rst is sampled at the clock edge.
  - If rst is high during ACCESS, that cycle's mem_we pulse still occurs, since it is combinational from the current state.
  - The next cycle is IDLE with no ack, and last_grant is reset.
- Simultaneous rst and req: reset wins, with no grant.
- Addresses are passed through unmodified. No range checks or wrap-around logic; the memory decodes them.

Decomposition:
- Shared include dmem_arb_defs.vh:
  - State encodings ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_ACK = 2'd2.
  - Port index localparams P_CPU = 0, P_LDR = 1.
- One sub-module, rr_arbiter2:
  - Inputs: req0, req1, last_grant.
  - Outputs: grant_valid, grant_id.
  - Combinational round-robin pick.
- The FSM, payload latch and rdata capture stay in the top module.

Test Plan:
- Port 0 write: req0=1, we0=1, addr0=4, wdata0=2 -> mem_we=1 with mem_addr=4, mem_wdata=2 exactly one cycle after sampling; ack0 two cycles after sampling; ack1 never asserts.
- Port 0 read back: with memory holding 2 at address 4, port 0 read of addr0=4 -> ack0 pulse with rdata0=2; mem_we stays 0 throughout.
- Tie: req0 and req1 both rise in the same cycle after reset (port 0 writes 7 to address 5; port 1 reads address 9) -> port 0 is served first (mem_addr=5, mem_we=1); port 1 is then granted in the IDLE cycle right after ack0, giving ack1 3 cycles later.
- Fairness: both req held high for 12 cycles -> grant order 0,1,0,1 with ack pulses every 3 cycles.
- Reset mid-op: port 1 read granted, rst=1 during ACCESS -> no ack1; busy=0 and rdata0/rdata1 = 0 in the following cycle; next tie goes to port 0.
- Idle hold: no requests for 10 cycles -> mem_we=0, busy=0, acks stay 0, and rdata values are retained.

Source files
------------

// File: rtl/data_memory_arbiter_pkg.sv
// rtl/data_memory_arbiter_pkg.sv - shared state encoding and port indices for the data memory arbiter
//
// Purpose: common definitions imported by data_memory_arbiter and rr_arbiter2.
//   state_t      : arbiter FSM states (IDLE -> ACCESS -> ACK -> IDLE)
//   P_CPU, P_LDR : requester indices (0 = CPU load/store, 1 = loader/debug)
package data_memory_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    localparam int P_CPU = 0;
    localparam int P_LDR = 1;

endpackage

// File: rtl/data_memory_arbiter_rr.sv
// rtl/data_memory_arbiter_rr.sv - two-way combinational round-robin pick
//
// Purpose: chooses which of two requesters gets the next memory slot.
// Ports:
//   req0, req1   in  : pending requests
//   last_grant   in  : port served most recently
//   grant_valid  out : at least one request pending
//   grant_id     out : chosen port index
module rr_arbiter2
    import data_memory_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        if (req0 && req1) begin
            // Tie: the port that was not served last wins.
            grant_id = ~last_grant;
        end else if (req1) begin
            grant_id = 1'(P_LDR);
        end else begin
            grant_id = 1'(P_CPU);
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// rtl/data_memory_arbiter.sv - round-robin arbiter sharing single-port DATA_MEMORY between two requesters
//
// Purpose: grants one access at a time (IDLE -> ACCESS -> ACK), drives the memory buses and
// holds per-port read data until that port's next read.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   req/addr/wdata/we[0,1]       : per-port request and payload, held until ack
//   ack[0,1], rdata[0,1]         : per-port one-cycle completion pulse and read data
//   mem_addr, mem_wdata, mem_we  : memory address bus, write-data bus, MW1 strobe
//   mem_rdata                    : combinational memory read data
//   busy                         : high whenever the FSM is not in IDLE
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int WDATA_W = 32,
    parameter int RDATA_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req0,
    input  logic               req1,
    input  logic [ADDR_W-1:0]  addr0,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [WDATA_W-1:0] wdata0,
    input  logic [WDATA_W-1:0] wdata1,
    input  logic               we0,
    input  logic               we1,
    output logic               ack0,
    output logic               ack1,
    output logic [RDATA_W-1:0] rdata0,
    output logic [RDATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WDATA_W-1:0] mem_wdata,
    output logic               mem_we,
    input  logic [RDATA_W-1:0] mem_rdata,
    output logic               busy
);

    state_t               state_q, state_d;
    logic                 last_grant_q, last_grant_d;
    logic                 gnt_id_q, gnt_id_d;
    logic                 we_q, we_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [WDATA_W-1:0]   wdata_q, wdata_d;
    logic [RDATA_W-1:0]   rdata0_q, rdata0_d;
    logic [RDATA_W-1:0]   rdata1_q, rdata1_d;
    logic                 ack0_q, ack0_d;
    logic                 ack1_q, ack1_d;

    logic                 grant_valid;
    logic                 grant_id;

    rr_arbiter2 u_rr (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant_q),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_id_d     = gnt_id_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    gnt_id_d = grant_id;
                    if (grant_id == 1'(P_LDR)) begin
                        addr_d  = addr1;
                        wdata_d = wdata1;
                        we_d    = we1;
                    end else begin
                        addr_d  = addr0;
                        wdata_d = wdata0;
                        we_d    = we0;
                    end
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Memory read is combinational, so data is valid by the end of this cycle.
                if (!we_q) begin
                    if (gnt_id_q == 1'(P_LDR)) begin
                        rdata1_d = mem_rdata;
                    end else begin
                        rdata0_d = mem_rdata;
                    end
                end
                last_grant_d = gnt_id_q;
                // Ack is registered so it lines up exactly with the ACK state.
                ack0_d  = (gnt_id_q == 1'(P_CPU));
                ack1_d  = (gnt_id_q == 1'(P_LDR));
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'(P_LDR);
            gnt_id_q     <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_id_q     <= gnt_id_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
        end
    end

    // Write strobe decodes the current state so it can never outlast the ACCESS cycle.
    assign mem_we    = (state_q == ST_ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb/tb_data_memory_arbiter.sv - scoreboard testbench for data_memory_arbiter
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, mem_we, busy;
    logic [15:0] rdata0, rdata1, mem_rdata;
    logic [31:0] mem_addr, mem_wdata;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sbq0[$];
    exp_t        sbq1[$];
    logic [31:0] ref_mem [256];
    logic [31:0] mem [256];
    logic [15:0] mon_last [2];
    logic        prev_we;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    data_memory_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .we0(we0), .we1(we1),
        .ack0(ack0), .ack1(ack1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    assign mem_rdata = mem[mem_addr[7:0]][15:0];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Issue a request and record what the arbiter must eventually return for it.
    task automatic start(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.we    = w;
        e.addr  = a;
        e.rdata = ref_mem[a[7:0]][15:0];
        if (w) ref_mem[a[7:0]] = d;
        if (p == 0) begin
            req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
            sbq0.push_back(e);
        end else begin
            req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
            sbq1.push_back(e);
        end
    endtask

    task automatic mon_port(input int p);
        exp_t        e;
        logic [15:0] rd;
        int          sz;
        rd = (p == 0) ? rdata0 : rdata1;
        sz = (p == 0) ? sbq0.size() : sbq1.size();
        if (sz == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_ack port%0d actual=ack required=no_ack", p);
            return;
        end
        if (p == 0) e = sbq0.pop_front();
        else        e = sbq1.pop_front();
        check($sformatf("ack%0d_addr", p), mem_addr, e.addr);
        if (e.we) begin
            check($sformatf("ack%0d_write_keeps_rdata", p), 32'(rd), 32'(mon_last[p]));
        end else begin
            check($sformatf("ack%0d_rdata", p), 32'(rd), 32'(e.rdata));
            mon_last[p] = e.rdata;
        end
    endtask

    always @(negedge clk) begin
        if (mem_we) check("mem_we_single_cycle", 32'(prev_we), 0);
        prev_we = mem_we;
        if (ack0 && ack1) check("acks_exclusive", 32'(ack1), 0);
        if (ack0) mon_port(0);
        if (ack1) mon_port(1);
    end

    task automatic wait_ack(input int p);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 12 && !got; k++) begin
            @(negedge clk);
            got = (p == 0) ? ack0 : ack1;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL ack_timeout port%0d actual=no_ack required=ack_within_12", p);
        end
    endtask

    task automatic drive(input int p, input int n);
        logic [31:0] a, d;
        logic        w;
        int          gap;
        for (int i = 0; i < n; i++) begin
            a    = $urandom;
            a[7] = p[0];
            d    = $urandom;
            w    = 1'($urandom_range(0, 1));
            start(p, w, a, d);
            wait_ack(p);
            gap = $urandom_range(0, 3);
            if (gap != 0 || i == n - 1) begin
                if (p == 0) req0 = 1'b0; else req1 = 1'b0;
                repeat (gap) @(negedge clk);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = '0;
            ref_mem[i] = '0;
        end
        mon_last[0] = '0;
        mon_last[1] = '0;
        prev_we = 1'b0;
        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        repeat (3) @(negedge clk);

        // reset state
        check("rst_ack0", 32'(ack0), 0);
        check("rst_ack1", 32'(ack1), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_rdata0", 32'(rdata0), 0);
        check("rst_rdata1", 32'(rdata1), 0);
        rst = 1'b0;

        // port 0 write 2 to address 4
        start(0, 1'b1, 32'd4, 32'd2);
        @(negedge clk);
        check("t1_mem_we", 32'(mem_we), 1);
        check("t1_mem_addr", mem_addr, 4);
        check("t1_mem_wdata", mem_wdata, 2);
        check("t1_no_ack_yet", 32'(ack0), 0);
        @(negedge clk);
        check("t1_ack0", 32'(ack0), 1);
        check("t1_ack1", 32'(ack1), 0);
        check("t1_we_off_in_ack", 32'(mem_we), 0);
        check("t1_busy_ack", 32'(busy), 1);
        req0 = 1'b0;
        @(negedge clk);
        check("t1_idle_busy", 32'(busy), 0);

        // port 0 read back address 4
        start(0, 1'b0, 32'd4, 32'd0);
        @(negedge clk);
        check("t2_mem_we", 32'(mem_we), 0);
        check("t2_mem_addr", mem_addr, 4);
        @(negedge clk);
        check("t2_ack0", 32'(ack0), 1);
        check("t2_rdata0", 32'(rdata0), 2);
        req0 = 1'b0;
        @(negedge clk);

        // tie right after reset: port 0 first, port 1 three cycles later
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mon_last[0] = '0;
        mon_last[1] = '0;
        start(0, 1'b1, 32'd5, 32'd7);
        start(1, 1'b0, 32'd9, 32'd0);
        @(negedge clk);
        check("t3_mem_addr_p0", mem_addr, 5);
        check("t3_mem_we_p0", 32'(mem_we), 1);
        @(negedge clk);
        check("t3_ack0", 32'(ack0), 1);
        check("t3_ack1_early", 32'(ack1), 0);
        req0 = 1'b0;
        @(negedge clk);
        check("t3_idle_ack1", 32'(ack1), 0);
        @(negedge clk);
        check("t3_mem_addr_p1", mem_addr, 9);
        check("t3_mem_we_p1", 32'(mem_we), 0);
        @(negedge clk);
        check("t3_ack1", 32'(ack1), 1);
        req1 = 1'b0;
        @(negedge clk);

        // fairness: both held high for 12 cycles, acks every 3 cycles alternating 0,1
        start(0, 1'b0, 32'd5, 32'd0);
        start(0, 1'b0, 32'd5, 32'd0);
        start(1, 1'b0, 32'd4, 32'd0);
        start(1, 1'b0, 32'd4, 32'd0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check($sformatf("t4_ack0_k%0d", k), 32'(ack0), 32'(k % 6 == 2));
            check($sformatf("t4_ack1_k%0d", k), 32'(ack1), 32'(k % 6 == 5));
            if (k == 11) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end

        // reset during a port 1 read
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'd9;
        @(negedge clk);
        check("t5_access_busy", 32'(busy), 1);
        check("t5_access_addr", mem_addr, 9);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        req1 = 1'b0;
        mon_last[0] = '0;
        mon_last[1] = '0;
        check("t5_no_ack1", 32'(ack1), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_rdata0", 32'(rdata0), 0);
        check("t5_rdata1", 32'(rdata1), 0);
        start(0, 1'b0, 32'd4, 32'd0);
        start(1, 1'b0, 32'd5, 32'd0);
        @(negedge clk);
        check("t5_tie_to_p0", mem_addr, 4);
        done = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            @(negedge clk);
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
            done = !req0 && !req1;
        end
        check("t5_drain_done", 32'(done), 1);

        // idle hold
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("t6_mem_we", 32'(mem_we), 0);
            check("t6_busy", 32'(busy), 0);
            check("t6_ack0", 32'(ack0), 0);
            check("t6_ack1", 32'(ack1), 0);
            check("t6_rdata0", 32'(rdata0), 32'(mon_last[0]));
            check("t6_rdata1", 32'(rdata1), 32'(mon_last[1]));
        end

        // randomized concurrent traffic on disjoint address halves
        fork
            drive(0, 25);
            drive(1, 25);
        join
        repeat (4) @(negedge clk);
        check("sbq0_empty", 32'(sbq0.size()), 0);
        check("sbq1_empty", 32'(sbq1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
